byte_load_sequencer: RTL
========================

Name: byte_load_sequencer

Overview:
- Multi-cycle controller between the 16-bit datapath and the 8-bit-wide data memory port.
- Runs byte loads with zero- or sign-extension, and halfword loads as two byte reads.
- Sequences the memory handshake and configures the extension mode. Delivers a 16-bit result to the register-file write path with a one-cycle done pulse.

Parameters:
- TIMEOUT_CYCLES, 15: max cycles mem_req may wait for mem_ack before the access aborts. 0 disables the timeout. Legal range 0..255.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  load request; sampled only when busy=0.
- addr  in  16  byte address, captured on accepted start.
- mode  in  2  00 byte zero-extend, 01 byte sign-extend, 10 halfword, 11 reserved (treated as 00).
- busy  out  1  high from the cycle after accept until done/err.
- done  out  1  one-cycle pulse; result valid.
- err  out  1  one-cycle pulse on timeout (or misalignment, see option).
- result  out  16  loaded value; holds until next done.
- mem_req  out  1  memory read request.
- mem_addr  out  16  memory byte address.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  8  read data byte.

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy=0, done=0, err=0, mem_req=0, mem_addr=0, result=16'h0000, timeout counter=0. Reset mid-access drops mem_req immediately. A late mem_ack is ignored.
- States: IDLE, RD_LO, RD_HI, FIN, ABORT.
- IDLE: if start=1, capture addr and mode, then go to RD_LO. start while busy=1 is ignored, not queued.
- RD_LO: mem_req=1, mem_addr=captured addr.
  - On mem_ack, latch mem_rdata into low byte.
  - Next state is RD_HI if mode=10, else FIN.
- RD_HI: mem_req=1, mem_addr=addr+1, wrapping modulo 2^16 (16'hFFFF+1 = 16'h0000).
  - On mem_ack, latch the high byte, then go to FIN.
- FIN: one cycle.
  - result = {8'h00, lo} for mode 00/11; {{8{lo[7]}}, lo} for 01; {hi, lo} for 10 (little-endian).
  - done=1; return to IDLE.
- ABORT: one cycle; err=1; result unchanged; return to IDLE.
- mem_req is held high until mem_ack. mem_addr is stable while mem_req=1. mem_ack with mem_req=0 is ignored.
- Timeout:
  - The counter clears on entry to RD_LO and RD_HI and increments each cycle mem_req=1 without ack.
  - If it reaches TIMEOUT_CYCLES without ack, go to ABORT next cycle, mem_req low.
  - An ack arriving on the same cycle the limit is reached wins (access completes).
- Latency with zero-wait memory (ack in first req cycle), start accepted at cycle T:
  - byte: done at T+2.
  - halfword: done at T+3.
  - Each wait cycle adds 1.
- busy=1 in RD_LO, RD_HI, FIN, ABORT; 0 in IDLE.
- done and err are never high together.
- A new start is accepted in the cycle after done/err, i.e. once IDLE is re-entered.

Optional Feature:
- Macro ALIGN_CHECK_EN.
- Defined: mode=10 with addr[0]=1 at accept issues no memory access. Goes IDLE->ABORT: err pulses at T+1, result unchanged.
- Undefined: odd-address halfword loads proceed normally, including address wrap at 16'hFFFF.

Test Plan:
- Reset with start=1, mem_ack=1 held -> all outputs 0, no mem_req. Release reset -> first accepted start behaves normally.
- mode=00, addr=16'h0040, ack in first cycle with rdata=8'hA5 -> mem_addr=16'h0040, done at T+2, result=16'h00A5. Repeat with mode=01 -> result=16'hFFA5. mode=01 with rdata=8'h7F -> result=16'h007F.
- mode=10, addr=16'h0100, rdata 8'h34 then 8'h12, two wait cycles on the second read -> mem_addr 16'h0100 then 16'h0101, done at T+5, result=16'h1234. A start pulsed while busy is ignored.
- mode=10, addr=16'hFFFF, option undefined -> second mem_addr=16'h0000, result assembled normally. Option defined -> no mem_req, err at T+1, result unchanged.
- TIMEOUT_CYCLES=4, never ack -> err pulse, mem_req deasserts, done=0, result unchanged. Ack on the 4th wait cycle instead -> completes with done. TIMEOUT_CYCLES=0 with a 300-cycle stall -> no err, done after ack.
- reset_n pulsed low while in RD_HI -> mem_req drops asynchronously, result=0. Subsequent mode=00 load completes correctly.

Source files
------------

// File: rtl/byte_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : byte_load_sequencer
// Function : Sequences byte/halfword loads over an 8-bit memory port with
//            zero/sign extension, timeout abort and done/err pulses.
//            Optional macro ALIGN_CHECK_EN aborts odd-address halfword loads.
// Revision : 1.0  initial release
// ============================================================================
module byte_load_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] addr,
  input  logic [1:0]  mode,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_LO = 3'd1;
  localparam logic [2:0] S_RD_HI = 3'd2;
  localparam logic [2:0] S_FIN   = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  localparam logic [1:0] C_MODE_SEXT = 2'b01;
  localparam logic [1:0] C_MODE_HALF = 2'b10;
  localparam logic [7:0] C_TIMEOUT    = 8'(TIMEOUT_CYCLES);
  localparam bit         C_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [15:0] r_addr;
  logic [1:0]  r_mode;
  logic [7:0]  r_lo;
  logic [7:0]  r_cnt;
  logic [15:0] r_result;

  logic        w_reading;
  logic        w_expired;
  logic        w_misaligned;
  logic        w_enter_rd;
  logic [7:0]  w_lo;
  logic [15:0] w_result;

`ifdef ALIGN_CHECK_EN
  assign w_misaligned = (mode == C_MODE_HALF) && addr[0];
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_reading = (r_state == S_RD_LO) || (r_state == S_RD_HI);
  // The limit is checked on the registered count, so an ack in that same cycle still wins.
  assign w_expired = C_TIMEOUT_EN && (r_cnt == C_TIMEOUT) && !mem_ack;
  assign w_enter_rd = ((w_next == S_RD_LO) && (r_state != S_RD_LO)) ||
                      ((w_next == S_RD_HI) && (r_state != S_RD_HI));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_misaligned ? S_ABORT : S_RD_LO;
        end
      end
      S_RD_LO: begin
        if (mem_ack) begin
          w_next = (r_mode == C_MODE_HALF) ? S_RD_HI : S_FIN;
        end else if (w_expired) begin
          w_next = S_ABORT;
        end
      end
      S_RD_HI: begin
        if (mem_ack) begin
          w_next = S_FIN;
        end else if (w_expired) begin
          w_next = S_ABORT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_FIN);
    err      = (r_state == S_ABORT);
    mem_req  = w_reading;
    mem_addr = 16'h0000;
    if (r_state == S_RD_LO) begin
      mem_addr = r_addr;
    end else if (r_state == S_RD_HI) begin
      mem_addr = r_addr + 16'd1;
    end
  end

  assign result = r_result;

  // Result is assembled on the edge into FIN so it is valid alongside done.
  assign w_lo = (r_state == S_RD_LO) ? mem_rdata : r_lo;
  always_comb begin
    case (r_mode)
      C_MODE_SEXT: w_result = {{8{w_lo[7]}}, w_lo};
      C_MODE_HALF: w_result = {mem_rdata, r_lo};
      default:     w_result = {8'h00, w_lo};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr   <= 16'h0000;
      r_mode   <= 2'b00;
      r_lo     <= 8'h00;
      r_cnt    <= 8'h00;
      r_result <= 16'h0000;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_addr <= addr;
        r_mode <= mode;
      end
      if ((r_state == S_RD_LO) && mem_ack) begin
        r_lo <= mem_rdata;
      end
      if (w_enter_rd) begin
        r_cnt <= 8'h00;
      end else if (w_reading && !mem_ack && (r_cnt != 8'hFF)) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_next == S_FIN) begin
        r_result <= w_result;
      end
    end
  end

endmodule
`default_nettype wire
